// File: rtl/alib_octree_pkg.sv
// Shared constants and types for the octree occupancy code packer:
// code-tier bases, prefix/length constants and the packer state encoding.
package alib_octree_pkg;

    // Largest code emitted by the rank-to-code table
    localparam int unsigned MAX_CODE_LEN = 13;

    // First rank of each code tier after tier 0
    localparam logic [7:0] TIER1_BASE = 8'd4;
    localparam logic [7:0] TIER2_BASE = 8'd12;
    localparam logic [7:0] TIER3_BASE = 8'd28;
    localparam logic [7:0] TIER4_BASE = 8'd92;

    // Unary-style prefixes selecting the tier
    localparam logic [0:0] PFX0 = 1'b0;
    localparam logic [1:0] PFX1 = 2'b10;
    localparam logic [2:0] PFX2 = 3'b110;
    localparam logic [3:0] PFX3 = 4'b1110;
    localparam logic [4:0] PFX4 = 5'b11110;

    // Total code length per tier (prefix + payload)
    localparam logic [3:0] LEN0 = 4'd3;
    localparam logic [3:0] LEN1 = 4'd5;
    localparam logic [3:0] LEN2 = 4'd7;
    localparam logic [3:0] LEN3 = 4'd10;
    localparam logic [3:0] LEN4 = 4'd13;

    typedef logic [MAX_CODE_LEN-1:0] code_t;
    typedef logic [3:0]              code_len_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } pk_state_e;

endpackage

// File: rtl/alib_code_lut.sv
// Combinational rank-to-prefix-code table. The code is returned
// right-aligned in MAX_CODE_LEN bits together with its length.
module alib_code_lut
    import alib_octree_pkg::*;
(
    input  logic [7:0] i_rank,
    output code_t      o_code,
    output code_len_t  o_len
);

    logic [7:0] off1;
    logic [7:0] off2;
    logic [7:0] off3;
    logic [7:0] off4;

    assign off1 = i_rank - TIER1_BASE;
    assign off2 = i_rank - TIER2_BASE;
    assign off3 = i_rank - TIER3_BASE;
    assign off4 = i_rank - TIER4_BASE;

    // Select the tier by rank range and build prefix + offset payload
    always_comb begin
        o_code = '0;
        o_len  = LEN4;
        if (i_rank < TIER1_BASE) begin
            o_code = {10'b0, PFX0, i_rank[1:0]};
            o_len  = LEN0;
        end else if (i_rank < TIER2_BASE) begin
            o_code = {8'b0, PFX1, off1[2:0]};
            o_len  = LEN1;
        end else if (i_rank < TIER3_BASE) begin
            o_code = {6'b0, PFX2, off2[3:0]};
            o_len  = LEN2;
        end else if (i_rank < TIER4_BASE) begin
            o_code = {3'b0, PFX3, off3[5:0]};
            o_len  = LEN3;
        end else begin
            o_code = {PFX4, off4};
            o_len  = LEN4;
        end
    end

endmodule

// File: rtl/alib_code_packer.sv
// Streaming packer: maps occupancy ranks to prefix codes and concatenates
// them MSB-first into WORD_W-bit output words, with a flush that drains
// the buffer as a zero-padded final word tagged last.
module alib_code_packer
    import alib_octree_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rank_valid,
    output logic                    o_rank_ready,
    input  logic [7:0]              i_rank,
    input  logic                    i_flush,
    output logic                    o_word_valid,
    input  logic                    i_word_ready,
    output logic [WORD_W-1:0]       o_word,
    output logic [$clog2(WORD_W):0] o_word_bits,
    output logic                    o_word_last,
    output logic                    o_flush_done,
    output logic                    o_busy,
    output logic [CNT_W-1:0]        o_total_bits
);

    // Buffer leaves 16 bits of headroom: a code is only accepted with
    // fewer than WORD_W bits held, so at most WORD_W-1+13 bits are live.
    localparam int BUF_W = WORD_W + 16;
    localparam int CW    = $clog2(BUF_W) + 1;
    localparam int BW    = $clog2(WORD_W) + 1;

    pk_state_e         state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  total_q, total_d;

    code_t             lut_code;
    code_len_t         lut_len;
    logic [BUF_W-1:0]  code_left;
    logic [BUF_W-1:0]  code_placed;

    logic              rank_ready;
    logic              word_valid;
    logic              word_last;
    logic [BW-1:0]     word_bits;
    logic              accept;
    logic              emit;

    alib_code_lut u_lut (
        .i_rank (i_rank),
        .o_code (lut_code),
        .o_len  (lut_len)
    );

    // Left-align the code at the buffer top, then drop it below the live bits
    always_comb begin
        code_left   = {lut_code, {(BUF_W - MAX_CODE_LEN){1'b0}}} << (4'(MAX_CODE_LEN) - lut_len);
        code_placed = code_left >> count_q;
    end

    // Output-side handshake signals, derived only from registered state
    always_comb begin
        rank_ready = (state_q == ST_RUN) && (count_q < CW'(WORD_W));
        word_valid = 1'b0;
        word_last  = 1'b0;
        word_bits  = BW'(WORD_W);
        case (state_q)
            ST_RUN: begin
                word_valid = (count_q >= CW'(WORD_W));
            end
            ST_FLUSH: begin
                word_valid = (count_q != '0);
                word_last  = (count_q <= CW'(WORD_W));
                word_bits  = (count_q <= CW'(WORD_W)) ? BW'(count_q) : BW'(WORD_W);
            end
            default: begin
                word_valid = 1'b0;
            end
        endcase
        accept = rank_ready && i_rank_valid;
        emit   = word_valid && i_word_ready;
    end

    // Next-state for buffer, counters and the RUN/FLUSH/DONE sequence
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        total_d = total_q;

        if (accept) begin
            buf_d   = buf_q | code_placed;
            count_d = count_q + CW'(lut_len);
            total_d = total_q + CNT_W'(lut_len);
        end else if (emit) begin
            if (count_q <= CW'(WORD_W)) begin
                // Only reachable in FLUSH: the final partial word drains everything
                buf_d   = '0;
                count_d = '0;
            end else begin
                buf_d   = buf_q << WORD_W;
                count_d = count_q - CW'(WORD_W);
            end
        end

        case (state_q)
            ST_RUN:   if (i_flush) state_d = ST_FLUSH;
            ST_FLUSH: if (count_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State registers; reset discards any buffered bits immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            buf_q   <= '0;
            count_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            total_q <= total_d;
        end
    end

    // Port drive; word metadata is zero whenever no word is offered
    always_comb begin
        o_rank_ready = rank_ready;
        o_word_valid = word_valid;
        o_word       = buf_q[BUF_W-1 -: WORD_W];
        o_word_bits  = word_valid ? word_bits : '0;
        o_word_last  = word_valid && word_last;
        o_flush_done = (state_q == ST_DONE);
        o_busy       = (state_q != ST_RUN) || (count_q != '0);
        o_total_bits = total_q;
    end

endmodule

// File: tb/tb_alib_code_packer.sv
// Directed bench for alib_code_packer with hand-computed expected words.
module tb_alib_code_packer;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst_n;
    logic              rank_valid;
    logic              rank_ready;
    logic [7:0]        rank;
    logic              flush;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word;
    logic [5:0]        word_bits;
    logic              word_last;
    logic              flush_done;
    logic              busy;
    logic [CNT_W-1:0]  total_bits;

    int n_chk = 0;
    int n_err = 0;

    alib_code_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rank_valid (rank_valid),
        .o_rank_ready (rank_ready),
        .i_rank       (rank),
        .i_flush      (flush),
        .o_word_valid (word_valid),
        .i_word_ready (word_ready),
        .o_word       (word),
        .o_word_bits  (word_bits),
        .o_word_last  (word_last),
        .o_flush_done (flush_done),
        .o_busy       (busy),
        .o_total_bits (total_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_rank(input logic [7:0] r);
        bit ok;
        ok = 1'b0;
        rank_valid = 1'b1;
        rank       = r;
        for (int i = 0; i < 50; i++) begin
            if (rank_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("rank_accept_timeout", ok, 1'b1);
        tick();
        rank_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic take_word(input string tag, input logic [31:0] exp_w,
                             input logic [5:0] exp_bits, input logic exp_last);
        bit ok;
        ok = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (word_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_valid_timeout"}, ok, 1'b1);
        chk({tag, "_word"}, word, exp_w);
        chk({tag, "_bits"}, word_bits, exp_bits);
        chk({tag, "_last"}, word_last, exp_last);
        tick();
        word_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (flush_done) begin
                ok = 1'b1;
                break;
            end
            chk({tag, "_no_word_before_done"}, word_valid, 1'b0);
            tick();
        end
        chk({tag, "_done_timeout"}, ok, 1'b1);
        tick();
        chk({tag, "_done_one_cycle"}, flush_done, 1'b0);
        chk({tag, "_idle_after_done"}, busy, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        rank_valid = 1'b0;
        rank       = 8'd0;
        flush      = 1'b0;
        word_ready = 1'b0;

        // Reset state, observed while reset is held
        #3;
        chk("rst_rank_ready", rank_ready, 1'b1);
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_word", word, 32'h0);
        chk("rst_word_bits", word_bits, 6'd0);
        chk("rst_word_last", word_last, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_total", total_bits, 32'd0);
        do_reset();

        // Ranks 3,4 then flush: 011 10000 -> 0x70000000, 8 bits
        send_rank(8'd3);
        send_rank(8'd4);
        chk("t1_total", total_bits, 32'd8);
        chk("t1_busy", busy, 1'b1);
        chk("t1_no_word_in_run", word_valid, 1'b0);
        pulse_flush();
        take_word("t1", 32'h7000_0000, 6'd8, 1'b1);
        wait_done("t1");

        // Four rank-92 codes with downstream ready
        do_reset();
        word_ready = 1'b1;
        send_rank(8'd92);
        send_rank(8'd92);
        send_rank(8'd92);
        chk("t2_ready_low_at_39", rank_ready, 1'b0);
        chk("t2_valid", word_valid, 1'b1);
        chk("t2_word0", word, 32'hF007_803C);
        chk("t2_bits0", word_bits, 6'd32);
        chk("t2_last0", word_last, 1'b0);
        tick();
        chk("t2_ready_after_emit", rank_ready, 1'b1);
        chk("t2_valid_after_emit", word_valid, 1'b0);
        word_ready = 1'b0;
        send_rank(8'd92);
        chk("t2_total", total_bits, 32'd52);
        pulse_flush();
        take_word("t2_final", 32'h01E0_0000, 6'd20, 1'b1);
        wait_done("t2");

        // Empty flush straight after reset: done two cycles after flush
        do_reset();
        flush = 1'b1;
        chk("t3_idle_before", busy, 1'b0);
        tick();
        flush = 1'b0;
        chk("t3_n1_busy", busy, 1'b1);
        chk("t3_n1_done", flush_done, 1'b0);
        chk("t3_n1_valid", word_valid, 1'b0);
        chk("t3_n1_rank_ready", rank_ready, 1'b0);
        tick();
        chk("t3_n2_done", flush_done, 1'b1);
        chk("t3_n2_busy", busy, 1'b1);
        chk("t3_n2_valid", word_valid, 1'b0);
        tick();
        chk("t3_n3_done", flush_done, 1'b0);
        chk("t3_n3_busy", busy, 1'b0);

        // Backpressure: 11 x rank 0 = 33 bits, downstream stalled 10 cycles
        do_reset();
        for (int i = 0; i < 11; i++) send_rank(8'd0);
        rank_valid = 1'b1;
        rank       = 8'd200;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", word_valid, 1'b1);
            chk("t4_hold_word", word, 32'h0);
            chk("t4_hold_bits", word_bits, 6'd32);
            chk("t4_hold_rank_ready", rank_ready, 1'b0);
            tick();
        end
        rank_valid = 1'b0;
        chk("t4_total", total_bits, 32'd33);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("t4_valid_after_emit", word_valid, 1'b0);
        chk("t4_busy_one_bit_left", busy, 1'b1);
        chk("t4_rank_ready_after", rank_ready, 1'b1);
        pulse_flush();
        take_word("t4_final", 32'h0, 6'd1, 1'b1);
        wait_done("t4");

        // Flush in the same cycle as accepting rank 255 (code 0x1EA3)
        do_reset();
        rank_valid = 1'b1;
        rank       = 8'd255;
        flush      = 1'b1;
        chk("t5_ready", rank_ready, 1'b1);
        tick();
        rank_valid = 1'b0;
        flush      = 1'b0;
        chk("t5_total", total_bits, 32'd13);
        take_word("t5", 32'hF518_0000, 6'd13, 1'b1);
        wait_done("t5");

        // Mid tiers: 11 -> 10111, 27 -> 1101111, 91 -> 1110111111
        do_reset();
        send_rank(8'd11);
        send_rank(8'd27);
        send_rank(8'd91);
        chk("t7_total", total_bits, 32'd22);
        pulse_flush();
        take_word("t7", 32'hBEFE_FC00, 6'd22, 1'b1);
        wait_done("t7");

        // Reset pulse during FLUSH with a partial word pending
        do_reset();
        send_rank(8'd3);
        pulse_flush();
        chk("t6_pending_valid", word_valid, 1'b1);
        chk("t6_pending_word", word, 32'h6000_0000);
        chk("t6_pending_bits", word_bits, 6'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", word_valid, 1'b0);
        chk("t6_async_word", word, 32'h0);
        chk("t6_async_bits", word_bits, 6'd0);
        chk("t6_async_last", word_last, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_total", total_bits, 32'd0);
        chk("t6_async_rank_ready", rank_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        word_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_stale_word", word_valid, 1'b0);
            chk("t6_no_done", flush_done, 1'b0);
        end
        chk("t6_ready_after", rank_ready, 1'b1);
        chk("t6_busy_after", busy, 1'b0);
        word_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alib_code_packer.md
Name: alib_code_packer

Overview:
Streaming entropy-code packer for the octree occupancy path. It accepts 8-bit occupancy ranks over a valid/ready handshake and maps each rank to a variable-length prefix code. The codes are concatenated MSB-first into WORD_W-bit words and presented on a valid/ready output stream to the octree bitstream writer/DMA. A flush request drains the buffer, emits a zero-padded final word tagged last, and reports completion.

Parameters:
WORD_W, 32, output word width in bits; legal values are 32 or 64.
CNT_W, 32, width of the accepted-bit counter; wraps modulo 2^CNT_W.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  reset, asynchronous assert, active-low.
i_rank_valid  in  1  rank available.
o_rank_ready  out  1  packer can accept a rank.
i_rank  in  8  occupancy rank, 0-255.
i_flush  in  1  single-cycle flush request.
o_word_valid  out  1  output word available.
i_word_ready  in  1  downstream accepts the word.
o_word  out  WORD_W  packed bits, first code bit at the MSB.
o_word_bits  out  $clog2(WORD_W)+1  number of meaningful bits in o_word, 1..WORD_W.
o_word_last  out  1  final word of a flushed stream.
o_flush_done  out  1  one-cycle completion pulse.
o_busy  out  1  state != RUN, or bit count != 0.
o_total_bits  out  CNT_W  code bits accepted since reset.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low on i_rst_n.
- While reset is asserted: state=RUN, buffer=0, count=0, and every output is 0 except o_rank_ready=1. Reset asserted in any state, including mid-flush, aborts immediately and discards buffered bits.
- Code table, combinational (rank r -> code, length):
  - r<4: 0 followed by r[1:0], 3 bits.
  - r<12: 10 followed by (r-4)[2:0], 5 bits.
  - r<28: 110 followed by (r-12)[3:0], 7 bits.
  - r<92: 1110 followed by (r-28)[5:0], 10 bits.
  - otherwise: 11110 followed by (r-92)[7:0], 13 bits.
- Buffer: WORD_W+16 bits, left-aligned. count holds the number of valid bits.
- An accepted code is placed at bit positions [top-count .. top-count-len+1]. count += len.
- o_total_bits += len on every accept.
- o_rank_ready = (state==RUN) && (count < WORD_W). It is registered-state only and has no path from i_word_ready. The maximum count is WORD_W-1+13, so the buffer cannot overflow.
- o_word = top WORD_W bits of the buffer; bits below count are 0.
- RUN state: o_word_valid = (count >= WORD_W), o_word_bits = WORD_W, o_word_last = 0.
- Accept and emit are mutually exclusive because ready needs count<WORD_W and valid needs count>=WORD_W. Sustained throughput is one rank per cycle, with a one-cycle stall per emitted word when i_word_ready=1.
- Emit handshake (valid && ready): buffer shifts left by WORD_W, count -= WORD_W.
- While o_word_valid=1 and i_word_ready=0, o_word, o_word_bits and o_word_last stay stable.
- States:
  - RUN: i_flush=1 moves to FLUSH. A rank accepted in the same cycle as i_flush is packed before the flush takes effect.
  - FLUSH: o_rank_ready=0. o_word_valid = (count != 0), o_word_bits = min(count, WORD_W), o_word_last = (count <= WORD_W). An emit with count <= WORD_W sets count=0. When count==0 at the start of a cycle, go to DONE. An empty flush therefore emits no word.
  - DONE: exactly one cycle, o_flush_done=1, then return to RUN.
- i_flush in FLUSH or DONE is ignored.
- Flush latency with an empty buffer: flush sampled in cycle N, done pulse in cycle N+2.
- i_rank is sampled only on a handshake. i_rank_valid may drop without being accepted.

Decomposition:
- Package alib_octree_pkg holds:
  - tier bases 4/12/28/92;
  - prefix and length constants 3/5/7/10/13;
  - MAX_CODE_LEN=13;
  - state encoding RUN/FLUSH/DONE.
- One combinational sub-module, alib_code_lut, performs the rank-to-{code,length} mapping and is instantiated once.
- The packer holds the buffer, counters and state machine.

Test Plan:
- Ranks 3,4 then flush: response is one word, o_word=0x70000000, o_word_bits=8, o_word_last=1; o_flush_done 1 cycle after the word handshake; o_total_bits=8.
- Ranks 92,92,92,92 with i_word_ready=1: response is o_rank_ready low after the 3rd accept (count=39). First word = 0xF007803C. The 4th rank is accepted after the emit. Flush gives a second word with bits=20 and last=1.
- Flush immediately after reset: response is no o_word_valid, o_flush_done high exactly 2 cycles after i_flush, o_busy high for those cycles.
- Backpressure: 11× rank 0 (33 bits) with i_word_ready=0 for 10 cycles. Response is o_word=0x00000000 held stable with valid=1, and o_rank_ready=0 throughout. After ready rises: one word, count=1.
- Flush asserted in the same cycle as accepting rank 255: response is the code 0x1EA3 (13 bits) included, final word 0xF5180000 with bits=13 and last=1.
- Reset pulse during FLUSH with a partial word pending: response is all outputs 0 asynchronously, o_rank_ready=1 after release, and no stale word emitted.
